// File: rtl/norm_pkg.sv
// Shared sizing for the normalization stage and the lane saturation helper.
package norm_pkg;

    localparam int DWIDTH      = 8;
    localparam int DESIGN_SIZE = 32;
    localparam int MASK_WIDTH  = 32;

    // Clamp a full-precision lane product into the signed DWIDTH output range.
    function automatic logic [DWIDTH-1:0] sat_dw(input logic signed [2*DWIDTH:0] x);
        logic signed [2*DWIDTH:0] max_v;
        logic signed [2*DWIDTH:0] min_v;
        max_v = {{(DWIDTH+2){1'b0}}, {(DWIDTH-1){1'b1}}};
        min_v = {{(DWIDTH+2){1'b1}}, {(DWIDTH-1){1'b0}}};
        if (x > max_v)      return max_v[DWIDTH-1:0];
        else if (x < min_v) return min_v[DWIDTH-1:0];
        else                return x[DWIDTH-1:0];
    endfunction

endpackage

// File: rtl/norm_lane.sv
// One normalization lane: stage 1 subtracts the mean, stage 2 scales and saturates.
import norm_pkg::*;

module norm_lane (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_out,
    input  logic              pass,
    input  logic [DWIDTH-1:0] in_lane,
    input  logic [DWIDTH-1:0] mean,
    input  logic [DWIDTH-1:0] inv_var,
    output logic [DWIDTH-1:0] out_lane
);

    logic signed [DWIDTH:0]   diff_q;
    logic signed [DWIDTH-1:0] iv_q;
    logic [DWIDTH-1:0]        raw_q;
    logic                     pass_q;
    logic signed [2*DWIDTH:0] prod;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q <= '0;
            iv_q   <= '0;
            raw_q  <= '0;
            pass_q <= 1'b0;
        end else if (load) begin
            diff_q <= $signed({in_lane[DWIDTH-1], in_lane}) - $signed({mean[DWIDTH-1], mean});
            iv_q   <= $signed(inv_var);
            raw_q  <= in_lane;
            pass_q <= pass;
        end
    end

    assign prod = diff_q * iv_q;

    // Output only moves on a valid result so it holds between vectors.
    always_ff @(posedge clk) begin
        if (reset)         out_lane <= '0;
        else if (load_out) out_lane <= pass_q ? raw_q : sat_dw(prod);
    end

endmodule

// File: rtl/norm.sv
// Per-lane normalization (in - mean) * inv_var with bypass, masking and batch-completion tracking.
import norm_pkg::*;

module norm (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_norm,
    input  logic [DWIDTH-1:0]             mean,
    input  logic [DWIDTH-1:0]             inv_var,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available,
    output logic                          done_norm
);

    localparam int CNT_MAX = DESIGN_SIZE + 2;
    localparam int CW      = $clog2(DESIGN_SIZE + 3);

    logic          v1, v2;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= in_data_available;
            v2 <= v1;
        end
    end

    assign out_data_available = v2;

    // Bypass is folded into the per-lane pass flag so it rides with its vector.
    for (genvar i = 0; i < DESIGN_SIZE; i++) begin : g_lane
        norm_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (in_data_available),
            .load_out (v1),
            .pass     (~enable_norm | ~validity_mask[i]),
            .in_lane  (inp_data[i*DWIDTH +: DWIDTH]),
            .mean     (mean),
            .inv_var  (inv_var),
            .out_lane (out_data[i*DWIDTH +: DWIDTH])
        );
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        count_next = cycle_count;
        if (!enable_norm)
            count_next = '0;
        else if (cycle_count == '0)
            count_next = in_data_available ? CW'(1) : '0;
        else if (cycle_count != CW'(CNT_MAX))
            count_next = cycle_count + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            done_norm   <= 1'b0;
        end else begin
            cycle_count <= count_next;
            done_norm   <= (count_next == CW'(CNT_MAX));
        end
    end

endmodule

// File: tb/tb_norm.sv
// Randomized and directed bench for norm, checked against an integer-arithmetic lane model.
module tb_norm;

    localparam int NL = 32;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable_norm;
    logic [DW-1:0]   mean;
    logic [DW-1:0]   inv_var;
    logic            in_data_available;
    logic [NL*DW-1:0] inp_data;
    logic [NL-1:0]   validity_mask;
    logic [NL*DW-1:0] out_data;
    logic            out_data_available;
    logic            done_norm;

    typedef struct {
        bit               valid;
        logic [NL*DW-1:0] data;
    } ent_t;

    ent_t             pipe_q[$];
    logic [NL*DW-1:0] exp_data;
    bit               exp_valid;
    int               cnt_m;
    int               total;
    int               bad;

    norm uut (
        .clk                (clk),
        .reset              (reset),
        .enable_norm        (enable_norm),
        .mean               (mean),
        .inv_var            (inv_var),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_norm          (done_norm)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_lane(logic [DW-1:0] x, logic [DW-1:0] m,
                                               logic [DW-1:0] iv, bit msk, bit en);
        int p;
        if (!en || !msk) return x;
        p = (int'($signed(x)) - int'($signed(m))) * int'($signed(iv));
        if (p > 127)  p = 127;
        if (p < -128) p = -128;
        return DW'(p);
    endfunction

    task automatic chk(input string tag, input logic [NL*DW-1:0] obs, input logic [NL*DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: predict this cycle's vector, advance, then compare all outputs.
    task automatic cycle();
        ent_t e;
        int   cnt_n;
        e.valid = in_data_available && !reset;
        for (int i = 0; i < NL; i++)
            e.data[i*DW +: DW] = ref_lane(inp_data[i*DW +: DW], mean, inv_var,
                                          validity_mask[i], enable_norm);
        if (reset || !enable_norm) cnt_n = 0;
        else if (cnt_m == 0)       cnt_n = in_data_available ? 1 : 0;
        else                       cnt_n = (cnt_m == NL + 2) ? NL + 2 : cnt_m + 1;
        @(posedge clk);
        #1;
        cnt_m = cnt_n;
        if (reset) begin
            pipe_q.delete();
            e.valid = 0;
            pipe_q.push_back(e);
            exp_valid = 0;
            exp_data  = '0;
        end else begin
            pipe_q.push_back(e);
            if (pipe_q.size() > 1) begin
                ent_t f;
                f = pipe_q.pop_front();
                exp_valid = f.valid;
                if (f.valid) exp_data = f.data;
            end
        end
        chk("valid", {255'b0, out_data_available}, {255'b0, exp_valid});
        chk("data", out_data, exp_data);
        chk("done", {255'b0, done_norm}, {255'b0, (cnt_m == NL + 2)});
        chk("cnt", (NL*DW)'(uut.cycle_count), (NL*DW)'(cnt_m));
    endtask

    task automatic set_ramp(input int base);
        for (int i = 0; i < NL; i++) inp_data[i*DW +: DW] = DW'(base + i);
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int i = 0; i < NL; i++) inp_data[i*DW +: DW] = v;
    endtask

    initial begin
        total = 0; bad = 0; cnt_m = 0;
        exp_data = '0; exp_valid = 0;
        reset = 1; enable_norm = 0; mean = '0; inv_var = '0;
        in_data_available = 0; inp_data = '0; validity_mask = '1;
        cycle(); cycle();
        reset = 0;
        cycle();

        // Basic: (20+i - 30) * 2
        enable_norm = 1; mean = 8'd30; inv_var = 8'd2; set_ramp(20);
        in_data_available = 1;
        cycle(); cycle();
        in_data_available = 0;
        cycle(); cycle(); cycle();
        chk("basic_l0",  (NL*DW)'(out_data[0*DW +: DW]),  (NL*DW)'(8'hEC));
        chk("basic_l9",  (NL*DW)'(out_data[9*DW +: DW]),  (NL*DW)'(8'hFE));
        chk("basic_l31", (NL*DW)'(out_data[31*DW +: DW]), (NL*DW)'(8'd42));

        // Mask: upper half passes raw input
        validity_mask = 32'h0000_FFFF; in_data_available = 1;
        cycle();
        in_data_available = 0;
        cycle(); cycle();
        chk("mask_l0",  (NL*DW)'(out_data[0*DW +: DW]),  (NL*DW)'(8'hEC));
        chk("mask_l16", (NL*DW)'(out_data[16*DW +: DW]), (NL*DW)'(8'd36));
        chk("mask_l31", (NL*DW)'(out_data[31*DW +: DW]), (NL*DW)'(8'd51));
        validity_mask = '1;

        // Saturation at both rails
        mean = 8'sd0 - 8'sd100; inv_var = 8'd4; set_all(8'd100); in_data_available = 1;
        cycle();
        mean = 8'd100; set_all(8'sd0 - 8'sd100);
        cycle();
        chk("sat_hi", (NL*DW)'(out_data[3*DW +: DW]), (NL*DW)'(8'h7F));
        in_data_available = 0;
        cycle();
        chk("sat_lo", (NL*DW)'(out_data[3*DW +: DW]), (NL*DW)'(8'h80));

        // Completion: single pulse, count to DESIGN_SIZE+2
        enable_norm = 0;
        cycle();
        enable_norm = 1; in_data_available = 1; mean = 8'd1; inv_var = 8'd1;
        cycle();
        in_data_available = 0;
        for (int i = 0; i < 33; i++) begin
            cycle();
            if (i == 31) chk("done_early", {255'b0, done_norm}, '0);
        end
        chk("done_set", {255'b0, done_norm}, {255'b0, 1'b1});
        chk("cnt_sat", (NL*DW)'(uut.cycle_count), (NL*DW)'(34));
        cycle(); cycle();
        chk("done_sticky", {255'b0, done_norm}, {255'b0, 1'b1});
        enable_norm = 0;
        cycle();
        chk("done_clr", {255'b0, done_norm}, '0);

        // Bypass
        set_ramp(0); in_data_available = 1; mean = 8'd50; inv_var = 8'd3;
        cycle();
        in_data_available = 0;
        cycle(); cycle();
        chk("byp_l5",  (NL*DW)'(out_data[5*DW +: DW]),  (NL*DW)'(8'd5));
        chk("byp_l31", (NL*DW)'(out_data[31*DW +: DW]), (NL*DW)'(8'd31));
        chk("byp_cnt", (NL*DW)'(uut.cycle_count), '0);

        // Reset one cycle after a valid vector
        enable_norm = 1; set_ramp(60); in_data_available = 1;
        cycle();
        in_data_available = 0; reset = 1;
        cycle();
        chk("rst_data",  out_data, '0);
        chk("rst_valid", {255'b0, out_data_available}, '0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst_novalid", {255'b0, out_data_available}, '0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset             = ($urandom_range(0, 79) == 0);
            enable_norm       = ($urandom_range(0, 9) != 0);
            in_data_available = $urandom_range(0, 1) == 1;
            mean              = DW'($urandom());
            inv_var           = DW'($urandom());
            validity_mask     = $urandom();
            for (int w = 0; w < NL*DW/32; w++) inp_data[w*32 +: 32] = $urandom();
            cycle();
        end
        reset = 0; in_data_available = 0;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
